// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the MMU data port: fetch vs load/store, one access
// in flight, wait-state stall, fault reporting and bounded fetch starvation.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_fault,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ls_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_wait,
    input  logic              mem_segv
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state_reg;
    state_t            state_next;
    logic              owner_reg;
    logic              we_reg;
    logic              fault_reg;
    logic [3:0]        starve_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    // Load/store wins ties unless fetch has been passed over STARVE_LIMIT times.
    logic grant_ls;
    logic grant_if;
    assign grant_ls = ls_req && !(if_req && (starve_reg == LIMIT));
    assign grant_if = if_req && !grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (if_req || ls_req) state_next = ACCESS;
            ACCESS:  if (!mem_wait)        state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_reg  <= 1'b0;
            we_reg     <= 1'b0;
            fault_reg  <= 1'b0;
            starve_reg <= 4'd0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
        end else begin
            if (state_reg == IDLE) begin
                if (grant_ls) begin
                    owner_reg <= 1'b1;
                    we_reg    <= ls_we;
                    addr_reg  <= ls_addr;
                    wdata_reg <= ls_wdata;
                end else if (grant_if) begin
                    owner_reg <= 1'b0;
                    we_reg    <= 1'b0;
                    addr_reg  <= if_addr;
                end
                // Counter only runs while fetch is actually waiting behind load/store.
                if (grant_if || !if_req) begin
                    starve_reg <= 4'd0;
                end else if (grant_ls && starve_reg != LIMIT) begin
                    starve_reg <= starve_reg + 4'd1;
                end
            end
            if (state_reg == ACCESS && !mem_wait) begin
                fault_reg <= mem_segv;
            end
        end
    end

    // Strobes decode straight from the state so reset drops them without an edge.
    always_comb begin
        mem_rd   = (state_reg == ACCESS) && !we_reg;
        mem_wd   = (state_reg == ACCESS) && we_reg;
        if_ack   = (state_reg == RESP) && !owner_reg;
        ls_ack   = (state_reg == RESP) && owner_reg;
        if_fault = if_ack && fault_reg;
        ls_fault = ls_ack && fault_reg;
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign if_rdata  = mem_rdata;
    assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: requester and MMU models
// drive on negedge, a transaction-level model predicts grants and responses.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_ack, if_fault;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          ls_req, ls_we, ls_ack, ls_fault;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata, ls_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rd, mem_wd, mem_wait, mem_segv;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .if_rdata(if_rdata), .if_fault(if_fault),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .mem_rdata(mem_rdata), .mem_wait(mem_wait), .mem_segv(mem_segv)
    );

    typedef struct {
        bit          owner;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          fault;
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    int   checks = 0;
    int   errors = 0;
    int   phase  = 0;   // 0 idle, 1 access, 2 response
    int   starve = 0;
    int   if_rate, ls_rate;
    bit   if_pend, ls_pend;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic bit segv_of(input logic [31:0] a);
        return a[7:4] == 4'hF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected transaction per observed ack.
    always begin : monitor
        txn_t t;
        @(posedge clk);
        #1;
        if (if_ack || ls_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ack_unexpected if_ack=%0b ls_ack=%0b required no ack", if_ack, ls_ack);
            end else begin
                t = exp_q.pop_front();
                check("ack_both", 64'(if_ack & ls_ack), 64'd0);
                check("ack_port", 64'(ls_ack), 64'(t.owner));
                if (t.owner) begin
                    check("ls_fault", 64'(ls_fault), 64'(t.fault));
                    if (!t.we) check("ls_rdata", 64'(ls_rdata), 64'(t.rdata));
                end else begin
                    check("if_fault", 64'(if_fault), 64'(t.fault));
                    check("if_rdata", 64'(if_rdata), 64'(t.rdata));
                end
                $display("txn %s we=%0b addr=%h wdata=%h rdata=%h fault=%0b",
                         t.owner ? "ls" : "if", t.we, t.addr, t.wdata,
                         t.owner ? ls_rdata : if_rdata, t.owner ? ls_fault : if_fault);
            end
        end
    end

    // One clock cycle: check outputs against the model, drive new inputs, advance the model.
    task automatic step();
        bit ls_wins;
        @(negedge clk);
        check("mem_rd", 64'(mem_rd), 64'(phase == 1 && !cur.we));
        check("mem_wd", 64'(mem_wd), 64'(phase == 1 && cur.we));
        check("if_ack", 64'(if_ack), 64'(phase == 2 && !cur.owner));
        check("ls_ack", 64'(ls_ack), 64'(phase == 2 && cur.owner));
        if (phase == 1) begin
            check("mem_addr", 64'(mem_addr), 64'(cur.addr));
            if (cur.we) check("mem_wdata", 64'(mem_wdata), 64'(cur.wdata));
        end

        // Requesters: drop on ack; after the grant, scramble the payload to prove it was latched.
        if (phase == 2) begin
            if (cur.owner) ls_pend = 1'b0;
            else           if_pend = 1'b0;
        end
        if (phase == 1) begin
            if (cur.owner) begin
                ls_addr  = $urandom;
                ls_wdata = $urandom;
            end else begin
                if_addr = $urandom;
            end
        end
        if (!if_pend && $urandom_range(99) < if_rate) begin
            if_pend = 1'b1;
            if_addr = $urandom;
        end
        if (!ls_pend && $urandom_range(99) < ls_rate) begin
            ls_pend  = 1'b1;
            ls_we    = 1'($urandom_range(1));
            ls_addr  = $urandom;
            ls_wdata = $urandom;
        end
        if_req = if_pend;
        ls_req = ls_pend;

        // MMU: meaningful wait/segv/data only in access; noise elsewhere must be ignored.
        if (phase == 1) begin
            mem_wait = ($urandom_range(99) < 30);
            if (!mem_wait) begin
                mem_segv  = segv_of(cur.addr);
                mem_rdata = rom(cur.addr);
            end else begin
                mem_segv  = 1'($urandom_range(1));
                mem_rdata = $urandom;
            end
        end else begin
            mem_wait  = 1'($urandom_range(1));
            mem_segv  = 1'($urandom_range(1));
            mem_rdata = $urandom;
        end

        case (phase)
            0: begin
                if (if_req || ls_req) begin
                    ls_wins = ls_req && !(if_req && starve == SL);
                    if (ls_wins) begin
                        cur.owner = 1'b1;
                        cur.we    = ls_we;
                        cur.addr  = ls_addr;
                        cur.wdata = ls_wdata;
                        if (if_req) starve = (starve + 1 > SL) ? SL : starve + 1;
                    end else begin
                        cur.owner = 1'b0;
                        cur.we    = 1'b0;
                        cur.addr  = if_addr;
                        cur.wdata = '0;
                        starve    = 0;
                    end
                    cur.rdata = rom(cur.addr);
                    cur.fault = segv_of(cur.addr);
                    exp_q.push_back(cur);
                    phase = 1;
                end
                if (!if_req) starve = 0;
            end
            1: if (!mem_wait) phase = 2;
            default: phase = 0;
        endcase
    endtask

    initial begin
        bit reached;
        rst = 1'b1;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0; mem_wait = 0; mem_segv = 0;
        if_pend = 0; ls_pend = 0; cur = '{default: '0};
        repeat (2) @(negedge clk);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_mem_wd", 64'(mem_wd), 64'd0);
        check("rst_if_ack", 64'(if_ack), 64'd0);
        check("rst_ls_ack", 64'(ls_ack), 64'd0);
        check("rst_if_fault", 64'(if_fault), 64'd0);
        check("rst_ls_fault", 64'(ls_fault), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        if_rate = 40; ls_rate = 40;
        repeat (1500) step();

        // Both requesters saturated: load/store streaks must be cut by fetch every SL grants.
        if_rate = 100; ls_rate = 100;
        repeat (300) step();

        // Reset while an access is on the port.
        if_rate = 60; ls_rate = 60;
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            step();
            reached = (phase == 1);
        end
        check("reach_access", 64'(reached), 64'd1);
        @(posedge clk);
        #2;
        check("access_before_rst", 64'(mem_rd | mem_wd), 64'd1);
        rst = 1'b1;
        #1;
        check("async_mem_rd", 64'(mem_rd), 64'd0);
        check("async_mem_wd", 64'(mem_wd), 64'd0);
        if_req = 0; ls_req = 0; if_pend = 0; ls_pend = 0;
        exp_q.delete();
        phase = 0; starve = 0; cur = '{default: '0};
        repeat (2) @(negedge clk);
        check("rst_hold_acks", 64'(if_ack | ls_ack), 64'd0);
        check("rst_hold_addr", 64'(mem_addr), 64'd0);
        rst = 1'b0;

        if_rate = 30; ls_rate = 50;
        repeat (800) step();

        // Drain: stop issuing and wait a bounded time for the last transaction.
        if_rate = 0; ls_rate = 0;
        for (int i = 0; i < 200; i++) begin
            if (phase == 0 && exp_q.size() == 0 && !if_pend && !ls_pend) break;
            step();
        end
        repeat (2) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
